// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash reader.
// Contents: READ opcode, address/length widths and the controller state enum.
package spi_flash_pkg;

  localparam int unsigned AddrWidth  = 24;
  localparam int unsigned LenWidth   = 16;
  localparam logic [7:0]  ReadOpcode = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StHold,
    StDesel
  } state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 byte engine: clock divider, SCLK generation, 8-bit shift register and bit counter.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start, tx_byte    - load a byte and begin shifting (may coincide with done for gapless chaining)
//   miso              - serial input, captured while SCLK is high
//   sclk, mosi        - serial clock (idles low) and serial output, MSB first
//   done, rx_byte     - done marks the edge that ends bit 7; rx_byte is valid in that cycle
module spi_bit_engine #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int unsigned DivW = 8;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic            active_q;
  logic            phase_q;   // 0: SCLK low half, 1: SCLK high half
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            miso_q;

  logic half_end;
  logic sample_now;
  logic sample_bit;

  assign half_end   = active_q && (div_q == DivLast);
  // MISO is captured on the first clk edge after SCLK rises.
  assign sample_now = active_q && phase_q && (div_q == '0);
  // With CLK_DIV=1 the capture edge and the falling edge coincide.
  assign sample_bit = sample_now ? miso : miso_q;

  assign done    = half_end && phase_q && (bit_q == 3'd7);
  assign rx_byte = {shift_q[6:0], sample_bit};
  assign sclk    = active_q & phase_q;
  assign mosi    = active_q & shift_q[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      miso_q   <= 1'b0;
    end else if (start) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= tx_byte;
    end else if (active_q) begin
      if (sample_now) begin
        miso_q <= miso;
      end
      if (half_end) begin
        div_q   <= '0;
        phase_q <= ~phase_q;
        if (phase_q) begin
          // Falling edge: shift the captured bit in and present the next MOSI bit.
          shift_q <= {shift_q[6:0], sample_bit};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
          end
        end
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) controller with valid/ready command and response streams.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            - command handshake; cmd_addr byte address, cmd_len bytes-1
//   rsp_valid/rsp_ready            - response handshake; rsp_data read byte, rsp_last final byte
//   busy                           - high whenever the controller is not idle
//   spi_ss, spi_sclk, spi_mosi     - flash select (active low), serial clock, serial output
//   spi_miso                       - flash serial data
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HIGH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [LenWidth-1:0]  cmd_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_last,
  output logic                 busy,
  output logic                 spi_ss,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam logic [LenWidth-1:0] DeselLoad = (CS_HIGH > 1) ? LenWidth'(CS_HIGH - 1) : '0;

  state_t state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  bytes_left_q;
  logic [LenWidth-1:0]  desel_q;
  logic [1:0]           addr_idx_q;
  logic [7:0]           rsp_data_q;
  logic                 init_q;   // holds cmd_ready off until the first edge after reset

  logic       cmd_fire;
  logic       rsp_fire;
  logic       last_byte;
  logic       eng_start;
  logic [7:0] eng_tx;
  logic       eng_sclk;
  logic       eng_mosi;
  logic       eng_done;
  logic [7:0] eng_rx;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign last_byte = (bytes_left_q == '0);

  spi_bit_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_engine (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .tx_byte(eng_tx),
    .miso   (spi_miso),
    .sclk   (eng_sclk),
    .mosi   (eng_mosi),
    .done   (eng_done),
    .rx_byte(eng_rx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_fire) state_d = StCmd;
      StCmd:   if (eng_done) state_d = StAddr;
      StAddr:  if (eng_done && (addr_idx_q == 2'd2)) state_d = StData;
      StData:  if (eng_done) state_d = StHold;
      StHold:  if (rsp_fire) state_d = last_byte ? StDesel : StData;
      StDesel: if (desel_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and byte-engine control. Each byte is started on the edge that finishes
  // the previous one, so command, address and data bits run back to back.
  always_comb begin
    eng_start = 1'b0;
    eng_tx    = 8'h00;
    unique case (state_q)
      StIdle: begin
        eng_start = cmd_fire;
        eng_tx    = ReadOpcode;
      end
      StCmd: begin
        eng_start = eng_done;
        eng_tx    = addr_q[23:16];
      end
      StAddr: begin
        eng_start = eng_done;
        if (addr_idx_q == 2'd0) begin
          eng_tx = addr_q[15:8];
        end else if (addr_idx_q == 2'd1) begin
          eng_tx = addr_q[7:0];
        end else begin
          eng_tx = 8'h00;
        end
      end
      StHold: begin
        eng_start = rsp_fire && !last_byte;
        eng_tx    = 8'h00;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == StIdle) && init_q;
  assign busy      = (state_q != StIdle);
  assign spi_ss    = !((state_q == StCmd) || (state_q == StAddr) ||
                       (state_q == StData) || (state_q == StHold));
  assign spi_sclk  = eng_sclk;
  assign spi_mosi  = ((state_q == StCmd) || (state_q == StAddr)) ? eng_mosi : 1'b0;
  assign rsp_valid = (state_q == StHold);
  assign rsp_last  = rsp_valid && last_byte;
  assign rsp_data  = rsp_data_q;

  // Datapath: latched command, byte counter, address byte index, deselect timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q       <= 1'b0;
      addr_q       <= '0;
      bytes_left_q <= '0;
      desel_q      <= '0;
      addr_idx_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      init_q <= 1'b1;
      if (cmd_fire) begin
        addr_q       <= cmd_addr;
        bytes_left_q <= cmd_len;
        addr_idx_q   <= '0;
      end
      if ((state_q == StAddr) && eng_done) begin
        addr_idx_q <= addr_idx_q + 2'd1;
      end
      if ((state_q == StData) && eng_done) begin
        rsp_data_q <= eng_rx;
      end
      if (rsp_fire && !last_byte) begin
        bytes_left_q <= bytes_left_q - LenWidth'(1);
      end
      if (rsp_fire && last_byte) begin
        desel_q <= DeselLoad;
      end else if ((state_q == StDesel) && (desel_q != '0)) begin
        desel_q <= desel_q - LenWidth'(1);
      end
    end
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter CS_HIGH, default 4, meaning the minimum clk cycles spi_ss stays high between transfers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_addr (input, 24: flash byte address) and cmd_len (input, 16: byte count minus 1).
REQ-006 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 8: read byte) and rsp_last (output, 1: final byte of the command).
REQ-007 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 SHALL have ports spi_ss (output, 1, active low), spi_sclk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1).

Function
REQ-009 SHALL implement the standard flash READ command 0x03 in SPI mode 0: SCLK idles low, MOSI changes on the falling edge, MISO is sampled on the rising edge, MSB first.
REQ-010 SHALL use FSM states IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (8 bits per byte) <-> HOLD -> DESEL -> IDLE.
REQ-011 SHALL assert cmd_ready only in IDLE; a cmd transaction is the cycle with cmd_valid and cmd_ready both high, and it latches cmd_addr and cmd_len.
REQ-012 SHALL drive spi_ss low in the cycle after acceptance (call it T), with spi_mosi already carrying bit 7 of 0x03.
REQ-013 SHALL give each SPI bit 2*CLK_DIV clk cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; the MISO sample is taken on the rise.
REQ-014 SHALL drive address bits 23..0 in ADDR; spi_mosi is don't-care during DATA and SHALL be driven 0.
REQ-015 SHALL assert rsp_valid for the first byte at cycle T + 80*CLK_DIV, the cycle sclk returns low after the 8th data bit, entering HOLD.
REQ-016 In HOLD, SHALL keep sclk low and ss low, with rsp_data and rsp_last stable, until rsp_valid && rsp_ready.
REQ-017 On acceptance of a byte that is not last, SHALL deassert rsp_valid next cycle and resume DATA with no inter-byte gap beyond that one cycle.
REQ-018 On acceptance of the last byte, SHALL raise spi_ss the next cycle and enter DESEL for CS_HIGH cycles before IDLE.
REQ-019 SHALL use a 16-bit down-counter for bytes remaining, loaded from cmd_len; rsp_last = (counter == 0), so cmd_len = 0xFFFF yields 65536 bytes.
REQ-020 SHALL NOT increment or wrap the address internally; flash-side wrap at the top of the array is the device's behaviour.
REQ-021 SHALL keep rsp_valid low except in HOLD, and SHALL ignore cmd_valid while busy.

Reset
REQ-022 While reset is high, SHALL asynchronously force state IDLE, spi_ss=1, spi_sclk=0, spi_mosi=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, cmd_ready=0, and clear all counters.
REQ-023 SHALL assert cmd_ready from the first clk edge after reset deasserts.
REQ-024 Reset asserted mid-transfer SHALL abort with ss high immediately; no partial byte is ever presented afterwards.

Structure
REQ-025 SHALL place the READ opcode constant 0x03, the state enum and the address/length widths in shared package spi_flash_pkg.
REQ-026 SHALL use one sub-module, spi_bit_engine, for the CLK_DIV divider, sclk generation, an 8-bit shift register and a bit counter, with a start/done handshake per byte.
REQ-027 SHALL keep the FSM, byte counter and stream handshakes in spi_flash_reader.

Verification
REQ-028 Bench SHALL cover a single-byte read: addr 0x012345, len 0, CLK_DIV=2, flash model returns 0xA5 -> MOSI shows 0x03 0x01 0x23 0x45; rsp_data=0xA5, rsp_last=1 at T+160; ss high next cycle.
REQ-029 Bench SHALL cover a 4-byte burst: len 3, bytes 0x11 0x22 0x33 0x44, rsp_ready always 1 -> four bytes in order, rsp_last only on 0x44, exactly 32 data SCLK rises.
REQ-030 Bench SHALL cover backpressure: rsp_ready held low 50 cycles on byte 2 -> sclk stays low, ss stays low and rsp_data is stable throughout; no bytes lost.
REQ-031 Bench SHALL cover a command while busy: cmd_valid pulsed mid-transfer -> cmd_ready=0 and the first command completes unaffected.
REQ-032 Bench SHALL cover reset mid-ADDR: reset at bit 10 of the address -> ss=1, sclk=0, rsp_valid=0 asynchronously; cmd_ready=1 one edge after release.
REQ-033 Bench SHALL cover the inter-command gap: two back-to-back commands with CS_HIGH=4 -> ss high for at least 4 cycles between them.
